// File: rtl/lbp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lbp_pkg
// Purpose  : Shared definitions for the LBP histogram stage: default sizes,
//            FSM state encoding and helpers that derive the interior address
//            range and pixel count from the image width.
// Revision : 1.0 - initial release
// ============================================================================
package lbp_pkg;

    localparam int IMG_W  = 64;
    localparam int ADDR_W = 12;
    localparam int CODE_W = 8;
    localparam int CNT_W  = 12;

    // First interior pixel: row 1, column 1.
    function automatic int lbp_first_addr(input int img_w);
        return img_w + 1;
    endfunction

    // Last interior pixel: row img_w-2, column img_w-2.
    function automatic int lbp_last_addr(input int img_w);
        return img_w * (img_w - 1) - 2;
    endfunction

    function automatic int lbp_interior_n(input int img_w);
        return (img_w - 2) * (img_w - 2);
    endfunction

    localparam int FIRST_ADDR = lbp_first_addr(IMG_W);
    localparam int LAST_ADDR  = lbp_last_addr(IMG_W);
    localparam int INTERIOR_N = lbp_interior_n(IMG_W);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lbp_interior_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : lbp_interior_addr_gen
// Purpose  : Walks the interior pixels of an IMG_W x IMG_W map in raster
//            order, skipping the one-pixel border.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            i_load       - load the first interior address
//            i_step       - advance to the next interior address
//            o_addr       - current (registered) address
//            o_last       - current address is the last interior pixel
// Revision : 1.0 - initial release
// ============================================================================
module lbp_interior_addr_gen #(
    parameter int IMG_W  = lbp_pkg::IMG_W,
    parameter int ADDR_W = lbp_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);
    import lbp_pkg::*;

    localparam int                c_col_w  = $clog2(IMG_W);
    localparam logic [ADDR_W-1:0] c_first  = ADDR_W'(lbp_first_addr(IMG_W));
    localparam logic [ADDR_W-1:0] c_last   = ADDR_W'(lbp_last_addr(IMG_W));
    localparam logic [c_col_w-1:0] c_edge  = c_col_w'(IMG_W - 2);

    logic [ADDR_W-1:0]  r_addr;
    logic [c_col_w-1:0] w_col;

    // IMG_W is a power of two, so the column is just the low address bits.
    assign w_col = r_addr[c_col_w-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= c_first;
        end else if (i_step) begin
            // From the last interior column, jump over the right border and
            // the next row's left border.
            r_addr <= r_addr + ((w_col == c_edge) ? ADDR_W'(3) : ADDR_W'(1));
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_addr == c_last);

endmodule
`default_nettype wire

// File: rtl/lbp_hist.sv
`default_nettype none
// ============================================================================
// Module   : lbp_hist
// Purpose  : Reads the interior codes of an LBP map, builds a 2**CODE_W bin
//            histogram in registers, streams the bins to a histogram memory
//            and pulses o_finish.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            i_start        - begin a pass (sampled in IDLE only)
//            o_lbp_addr     - LBP memory read address
//            o_lbp_oe       - LBP memory read request
//            i_lbp_data     - read data, valid one cycle after o_lbp_oe
//            o_hist_addr    - histogram write address (bin index)
//            o_hist_wen     - histogram write enable
//            o_hist_data    - bin count being written
//            o_busy         - high whenever not IDLE
//            o_finish       - one-cycle done pulse
// Revision : 1.0 - initial release
// ============================================================================
module lbp_hist #(
    parameter int IMG_W  = lbp_pkg::IMG_W,
    parameter int ADDR_W = lbp_pkg::ADDR_W,
    parameter int CODE_W = lbp_pkg::CODE_W,
    parameter int CNT_W  = lbp_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    output logic [ADDR_W-1:0] o_lbp_addr,
    output logic              o_lbp_oe,
    input  logic [CODE_W-1:0] i_lbp_data,
    output logic [CODE_W-1:0] o_hist_addr,
    output logic              o_hist_wen,
    output logic [CNT_W-1:0]  o_hist_data,
    output logic              o_busy,
    output logic              o_finish
);
    import lbp_pkg::*;

    localparam int                c_bins     = 2 ** CODE_W;
    localparam logic [CNT_W-1:0]  c_cnt_max  = '1;
    localparam logic [CODE_W-1:0] c_last_bin = '1;

    state_t             r_state;
    state_t             w_state_n;
    logic               r_lbp_oe;
    logic               w_lbp_oe_n;
    logic               r_rd_valid;
    logic               r_hist_wen;
    logic               w_hist_wen_n;
    logic [CODE_W-1:0]  r_hist_addr;
    logic [CODE_W-1:0]  w_hist_addr_n;
    logic [CNT_W-1:0]   r_hist_data;
    logic [CNT_W-1:0]   w_hist_data_n;
    logic               r_busy;
    logic               r_finish;
    logic               w_finish_n;
    logic               w_load;
    logic               w_step;
    logic               w_clear;
    logic               w_addr_last;
    logic [CODE_W-1:0]  w_out_idx;
    logic [CNT_W-1:0]   w_out_val;
    logic [CNT_W-1:0]   r_bin [c_bins];

    lbp_interior_addr_gen #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_step (w_step),
        .o_addr (o_lbp_addr),
        .o_last (w_addr_last)
    );

    // ------------------------------------------------------------------
    // Bin array: one increment per returned code, saturating.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            for (int i = 0; i < c_bins; i++) begin
                r_bin[i] <= '0;
            end
        end else if (r_rd_valid && (r_bin[i_lbp_data] != c_cnt_max)) begin
            r_bin[i_lbp_data] <= r_bin[i_lbp_data] + CNT_W'(1);
        end
    end

    // Value of the next bin to stream. The first bin is loaded on the same
    // edge that the DRAIN-cycle code is accumulated, so the pending
    // increment is folded in here.
    always_comb begin
        w_out_idx = (r_state == OUT) ? (r_hist_addr + CODE_W'(1)) : '0;
        w_out_val = r_bin[w_out_idx];
        if (r_rd_valid && (i_lbp_data == w_out_idx) && (w_out_val != c_cnt_max)) begin
            w_out_val = w_out_val + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and next values of the registered outputs.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n     = r_state;
        w_lbp_oe_n    = 1'b0;
        w_hist_wen_n  = 1'b0;
        w_hist_addr_n = r_hist_addr;
        w_hist_data_n = r_hist_data;
        w_finish_n    = 1'b0;
        w_load        = 1'b0;
        w_step        = 1'b0;
        w_clear       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_n = CLEAR;
                end
            end
            CLEAR: begin
                w_clear    = 1'b1;
                w_load     = 1'b1;
                w_lbp_oe_n = 1'b1;
                w_state_n  = READ;
            end
            READ: begin
                if (w_addr_last) begin
                    w_state_n = DRAIN;
                end else begin
                    w_step     = 1'b1;
                    w_lbp_oe_n = 1'b1;
                end
            end
            DRAIN: begin
                w_hist_wen_n  = 1'b1;
                w_hist_addr_n = '0;
                w_hist_data_n = w_out_val;
                w_state_n     = OUT;
            end
            OUT: begin
                if (r_hist_addr == c_last_bin) begin
                    w_finish_n = 1'b1;
                    w_state_n  = DONE;
                end else begin
                    w_hist_wen_n  = 1'b1;
                    w_hist_addr_n = w_out_idx;
                    w_hist_data_n = w_out_val;
                end
            end
            DONE: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lbp_oe    <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_hist_wen  <= 1'b0;
            r_hist_addr <= '0;
            r_hist_data <= '0;
            r_busy      <= 1'b0;
            r_finish    <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_lbp_oe    <= w_lbp_oe_n;
            r_rd_valid  <= r_lbp_oe;
            r_hist_wen  <= w_hist_wen_n;
            r_hist_addr <= w_hist_addr_n;
            r_hist_data <= w_hist_data_n;
            r_busy      <= (w_state_n != IDLE);
            r_finish    <= w_finish_n;
        end
    end

    assign o_lbp_oe    = r_lbp_oe;
    assign o_hist_wen  = r_hist_wen;
    assign o_hist_addr = r_hist_addr;
    assign o_hist_data = r_hist_data;
    assign o_busy      = r_busy;
    assign o_finish    = r_finish;

endmodule
`default_nettype wire

// File: tb/tb_lbp_hist.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lbp_hist
// Purpose  : Self-checking bench for lbp_hist. A memory model answers the
//            read port; expected bins are computed from the map and queued,
//            then popped as the DUT streams them out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lbp_hist;
    localparam int IMG_W   = 64;
    localparam int ADDR_W  = 12;
    localparam int CODE_W  = 8;
    localparam int CNT_W   = 12;
    localparam int N_INT   = (IMG_W - 2) * (IMG_W - 2);
    localparam int LATENCY = 1 + N_INT + 1 + 256;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_start = 1'b0;
    logic [ADDR_W-1:0] o_lbp_addr;
    logic              o_lbp_oe;
    logic [CODE_W-1:0] lbp_data = '0;
    logic [CODE_W-1:0] o_hist_addr;
    logic              o_hist_wen;
    logic [CNT_W-1:0]  o_hist_data;
    logic              o_busy;
    logic              o_finish;

    logic [7:0]  mem [IMG_W*IMG_W];
    logic [7:0]  q_addr [$];
    logic [11:0] q_data [$];

    int chk = 0;
    int err = 0;
    int cyc = 0;

    int oe_cnt = 0, addr_bad = 0, border_cnt = 0;
    int wr_cnt = 0, sum = 0, fin_cnt = 0, spur = 0;
    int t_busy = 0, er = 1, ec = 1;
    bit prev_busy = 1'b0;
    int last_bin255 = 0;

    lbp_hist dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .o_lbp_addr  (o_lbp_addr),
        .o_lbp_oe    (o_lbp_oe),
        .i_lbp_data  (lbp_data),
        .o_hist_addr (o_hist_addr),
        .o_hist_wen  (o_hist_wen),
        .o_hist_data (o_hist_data),
        .o_busy      (o_busy),
        .o_finish    (o_finish)
    );

    always #5 clk = ~clk;

    // Synchronous-read LBP memory: data one cycle after the request.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_lbp_oe) lbp_data <= mem[o_lbp_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Monitor: address trace, scoreboard pops, finish latency.
    always @(negedge clk) begin
        if (o_busy === 1'b1 && !prev_busy) begin
            t_busy = cyc;
            er = 1;
            ec = 1;
        end
        prev_busy = (o_busy === 1'b1);
        if (o_lbp_oe === 1'b1) begin
            oe_cnt++;
            if (o_lbp_addr !== ADDR_W'(er * IMG_W + ec)) addr_bad++;
            if (o_lbp_addr / IMG_W == 0 || o_lbp_addr / IMG_W == IMG_W - 1 ||
                o_lbp_addr % IMG_W == 0 || o_lbp_addr % IMG_W == IMG_W - 1) border_cnt++;
            ec++;
            if (ec == IMG_W - 1) begin
                ec = 1;
                er++;
            end
        end
        if (o_hist_wen === 1'b1) begin
            wr_cnt++;
            sum += int'(o_hist_data);
            if (q_addr.size() == 0) begin
                spur++;
            end else begin
                check("hist_addr", 32'(o_hist_addr), 32'(q_addr.pop_front()));
                check("hist_data", 32'(o_hist_data), 32'(q_data.pop_front()));
            end
        end
        if (o_finish === 1'b1) begin
            fin_cnt++;
            check("finish_latency", cyc - t_busy, LATENCY);
            check("wen_in_done", 32'(o_hist_wen), 0);
        end
    end

    task automatic fill(input int mode);
        for (int r = 0; r < IMG_W; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (r == 0 || c == 0 || r == IMG_W - 1 || c == IMG_W - 1)
                    mem[r*IMG_W + c] = 8'h55;
                else if (mode == 0) mem[r*IMG_W + c] = 8'h00;
                else if (mode == 1) mem[r*IMG_W + c] = 8'((r + c) & 255);
                else if (mode == 2) mem[r*IMG_W + c] = 8'hFF;
                else                mem[r*IMG_W + c] = 8'($urandom_range(0, 255));
            end
        end
    endtask

    task automatic push_expected();
        int h [256];
        for (int i = 0; i < 256; i++) h[i] = 0;
        for (int r = 1; r < IMG_W - 1; r++)
            for (int c = 1; c < IMG_W - 1; c++)
                h[mem[r*IMG_W + c]]++;
        for (int i = 0; i < 256; i++) begin
            q_addr.push_back(8'(i));
            q_data.push_back(12'(h[i]));
        end
        last_bin255 = h[255];
    endtask

    task automatic clear_counters();
        oe_cnt = 0; addr_bad = 0; border_cnt = 0;
        wr_cnt = 0; sum = 0; fin_cnt = 0; spur = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
    endtask

    task automatic wait_busy();
        int k = 0;
        while (o_busy !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        check("busy_rise", 32'(o_busy), 1);
    endtask

    task automatic wait_fin();
        int k = 0;
        while (o_finish !== 1'b1 && k < 6000) begin @(negedge clk); k++; end
        check("finish_seen", 32'(o_finish), 1);
    endtask

    task automatic end_pass(input int n);
        repeat (10) @(negedge clk);
        check("queue_drained", q_addr.size(), 0);
        check("write_count", wr_cnt, 256 * n);
        check("bin_sum", sum, N_INT * n);
        check("finish_count", fin_cnt, n);
        check("oe_count", oe_cnt, N_INT * n);
        check("addr_trace_bad", addr_bad, 0);
        check("border_reads", border_cnt, 0);
        check("spurious_writes", spur, 0);
        check("idle_busy", 32'(o_busy), 0);
        check("lbp_addr_hold", 32'(o_lbp_addr), 4030);
        check("hist_addr_hold", 32'(o_hist_addr), 255);
        check("hist_data_hold", 32'(o_hist_data), last_bin255);
        clear_counters();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        fill(0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_lbp_addr",  32'(o_lbp_addr), 0);
        check("rst_lbp_oe",    32'(o_lbp_oe), 0);
        check("rst_hist_addr", 32'(o_hist_addr), 0);
        check("rst_hist_wen",  32'(o_hist_wen), 0);
        check("rst_hist_data", 32'(o_hist_data), 0);
        check("rst_busy",      32'(o_busy), 0);
        check("rst_finish",    32'(o_finish), 0);
        rst = 1'b0;
        clear_counters();

        // All-zero interior
        fill(0); push_expected(); pulse_start(); wait_fin(); end_pass(1);

        // (row+col) pattern
        fill(1); push_expected(); pulse_start(); wait_fin(); end_pass(1);

        // Every interior code 0xFF: back-to-back hits on one bin
        fill(2); push_expected(); pulse_start(); wait_fin(); end_pass(1);

        // Random map with start pulses during READ and during OUT
        fill(3); push_expected(); pulse_start(); wait_busy();
        repeat (2000) @(negedge clk);
        i_start = 1'b1; @(negedge clk); i_start = 1'b0;
        repeat (1898) @(negedge clk);
        i_start = 1'b1; @(negedge clk); i_start = 1'b0;
        wait_fin();
        end_pass(1);

        // start held high: second pass begins right after DONE -> IDLE
        fill(1); push_expected(); push_expected();
        @(negedge clk); i_start = 1'b1;
        wait_fin();
        @(negedge clk);
        check("held_idle_gap", 32'(o_busy), 0);
        @(negedge clk);
        check("held_restart", 32'(o_busy), 1);
        i_start = 1'b0;
        wait_fin();
        end_pass(2);

        // Reset at READ cycle 1000, then a fresh full pass
        fill(0); pulse_start(); wait_busy();
        repeat (1000) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_lbp_addr",  32'(o_lbp_addr), 0);
        check("mid_rst_lbp_oe",    32'(o_lbp_oe), 0);
        check("mid_rst_hist_wen",  32'(o_hist_wen), 0);
        check("mid_rst_hist_addr", 32'(o_hist_addr), 0);
        check("mid_rst_hist_data", 32'(o_hist_data), 0);
        check("mid_rst_busy",      32'(o_busy), 0);
        check("mid_rst_finish",    32'(o_finish), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_writes", wr_cnt, 0);
        check("abort_finish", fin_cnt, 0);
        check("abort_busy", 32'(o_busy), 0);
        clear_counters();
        push_expected(); pulse_start(); wait_fin(); end_pass(1);

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
`default_nettype wire
